// File: rtl/pll_clock_monitor_if.sv
// rtl/pll_clock_monitor_if.sv - signal bundle between the PLL monitor and its system
//
// Purpose: groups the asynchronous PLL observation inputs, the fault clear
// strobe and the qualification/measurement outputs of pll_clock_monitor.
//
// Signals:
//   pll_clk      PLL CLKOUT, asynchronous to the monitor clock
//   pll_lock     PLL LOCK, asynchronous to the monitor clock
//   clr_fault    single-cycle strobe clearing fault_flag
//   rst_out      active-high reset for downstream logic
//   pll_ready    high while the PLL is qualified
//   freq_count   rising-edge count of the last completed window
//   count_valid  one-cycle pulse when freq_count updates
//   fault_flag   sticky fault indicator
//   fault_count  saturating number of faults
//
// Modports: master drives the PLL-side inputs and observes results (system /
// bench side); slave is the monitor itself.

interface pll_clock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             pll_clk;
    logic             pll_lock;
    logic             clr_fault;
    logic             rst_out;
    logic             pll_ready;
    logic [CNT_W-1:0] freq_count;
    logic             count_valid;
    logic             fault_flag;
    logic [7:0]       fault_count;

    modport master (
        output pll_clk,
        output pll_lock,
        output clr_fault,
        input  rst_out,
        input  pll_ready,
        input  freq_count,
        input  count_valid,
        input  fault_flag,
        input  fault_count
    );

    modport slave (
        input  pll_clk,
        input  pll_lock,
        input  clr_fault,
        output rst_out,
        output pll_ready,
        output freq_count,
        output count_valid,
        output fault_flag,
        output fault_count
    );
endinterface

// File: rtl/pll_clock_monitor.sv
// rtl/pll_clock_monitor.sv - qualifies PLL lock and output frequency before releasing downstream reset
//
// Purpose: runs on the 27 MHz board clock, synchronises the PLL LOCK and
// CLKOUT signals, counts CLKOUT rising edges over fixed windows and holds
// rst_out until lock is stable and GOOD_WINDOWS consecutive windows are in
// range. Loss of lock or a bad window once qualified raises a sticky fault.
//
// Ports:
//   clk   in   reference clock (27 MHz)
//   rst   in   asynchronous active-high reset
//   mon   slave modport of pll_clock_monitor_if:
//         pll_clk, pll_lock, clr_fault in;
//         rst_out, pll_ready, freq_count, count_valid, fault_flag, fault_count out
//
// All outputs come straight from flops.

module pll_clock_monitor #(
    parameter int WINDOW       = 2700,
    parameter int EXP_MIN      = 380,
    parameter int EXP_MAX      = 392,
    parameter int GOOD_WINDOWS = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    pll_clock_monitor_if.slave  mon
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(EXP_MAX);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_MEASURE   = 2'd1,
        S_READY     = 2'd2,
        S_FAULT     = 2'd3
    } state_t;

    state_t state, state_n;

    // Synchronisers
    logic lock_m, lock_s;
    logic pclk_m, pclk_s, pclk_d;
    logic edge_p;

    // Measurement
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] freq_q;
    logic             count_valid_q;
    logic [CNT_W:0]   close_sum;
    logic [CNT_W-1:0] close_sat;
    logic             in_range;

    // Qualification and status
    logic [GOOD_W-1:0] good_cnt, good_n;
    logic              measure_start;
    logic              rst_out_q;
    logic              pll_ready_q;
    logic              fault_flag_q;
    logic [7:0]        fault_count_q;

    // Two-flop synchronisers; the pll_clk path adds a delay flop and a
    // registered rising-edge pulse, so edge_p appears 3 clk edges after the
    // CLKOUT rise has been sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            pclk_m <= 1'b0;
            pclk_s <= 1'b0;
            pclk_d <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            lock_m <= mon.pll_lock;
            lock_s <= lock_m;
            pclk_m <= mon.pll_clk;
            pclk_s <= pclk_m;
            pclk_d <= pclk_s;
            edge_p <= pclk_s & ~pclk_d;
        end
    end

    // An edge arriving on the terminal window cycle is folded into the
    // closing count rather than carried into the next window.
    assign close_sum = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, edge_p};
    assign close_sat = close_sum[CNT_W] ? {CNT_W{1'b1}} : close_sum[CNT_W-1:0];

    // Evaluated against the freshly registered count while count_valid is high.
    assign in_range = (freq_q >= MIN_C) && (freq_q <= MAX_C);

    // Window and edge counters run freely; entering MEASURE restarts them so
    // the first qualifying window is a full one. A window closing on that very
    // cycle is dropped so a stale WAIT_LOCK count cannot be scored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt       <= '0;
            edge_cnt      <= '0;
            freq_q        <= '0;
            count_valid_q <= 1'b0;
        end else if (measure_start) begin
            win_cnt       <= '0;
            edge_cnt      <= '0;
            count_valid_q <= 1'b0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt       <= '0;
            edge_cnt      <= '0;
            freq_q        <= close_sat;
            count_valid_q <= 1'b1;
        end else begin
            win_cnt       <= win_cnt + WIN_W'(1);
            count_valid_q <= 1'b0;
            if (edge_p && (edge_cnt != {CNT_W{1'b1}})) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

    // FSM next state
    always_comb begin
        state_n       = state;
        good_n        = good_cnt;
        measure_start = 1'b0;
        case (state)
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n       = S_MEASURE;
                    good_n        = '0;
                    measure_start = 1'b1;
                end
            end
            S_MEASURE: begin
                // Dropping lock here is not a fault: it was never qualified.
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                end else if (count_valid_q) begin
                    if (in_range) begin
                        good_n = good_cnt + GOOD_W'(1);
                        if (good_cnt == GOOD_LAST) begin
                            state_n = S_READY;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
            end
            S_READY: begin
                // Lock loss and a bad window together still give one FAULT.
                if (!lock_s || (count_valid_q && !in_range)) begin
                    state_n = S_FAULT;
                end
            end
            S_FAULT: begin
                state_n = S_WAIT_LOCK;
            end
            default: begin
                state_n = S_WAIT_LOCK;
            end
        endcase
    end

    // State register; rst_out/pll_ready follow the next state so they change
    // on the same edge as the state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT_LOCK;
            good_cnt    <= '0;
            rst_out_q   <= 1'b1;
            pll_ready_q <= 1'b0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_n;
            rst_out_q   <= (state_n != S_READY);
            pll_ready_q <= (state_n == S_READY);
        end
    end

    // Fault bookkeeping; a set during the FAULT cycle takes priority over a
    // coincident clr_fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_flag_q  <= 1'b0;
            fault_count_q <= 8'd0;
        end else if (state == S_FAULT) begin
            fault_flag_q <= 1'b1;
            if (fault_count_q != 8'hFF) begin
                fault_count_q <= fault_count_q + 8'd1;
            end
        end else if (mon.clr_fault) begin
            fault_flag_q <= 1'b0;
        end
    end

    assign mon.rst_out     = rst_out_q;
    assign mon.pll_ready   = pll_ready_q;
    assign mon.freq_count  = freq_q;
    assign mon.count_valid = count_valid_q;
    assign mon.fault_flag  = fault_flag_q;
    assign mon.fault_count = fault_count_q;

endmodule

// File: tb/tb_pll_clock_monitor.sv
// tb/tb_pll_clock_monitor.sv - self-checking bench for pll_clock_monitor

module tb_pll_clock_monitor;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_clock_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    pll_clock_monitor #(
        .WINDOW      (2700),
        .EXP_MIN     (380),
        .EXP_MAX     (392),
        .GOOD_WINDOWS(4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // PLL clock generator: period gen_per clk cycles, gen_hi of them high.
    int gen_per   = 7;
    int gen_hi    = 4;
    int gen_phase = 0;
    bit gen_en    = 1'b1;

    always @(negedge clk) begin
        if (gen_en) begin
            gen_phase = (gen_phase + 1 >= gen_per) ? 0 : gen_phase + 1;
            mon_if.pll_clk = (gen_phase < gen_hi);
        end else begin
            mon_if.pll_clk = 1'b0;
        end
    end

    // Release reset while pll_clk is low so no pre-reset edge is replayed.
    task automatic release_rst();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mon_if.pll_clk == 1'b0) break;
        end
        rst = 1'b0;
    endtask

    task automatic wait_cv(output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            cycles++;
            if (mon_if.count_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        mon_if.pll_lock  = 1'b1;
        mon_if.clr_fault = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (mon_if.rst_out !== 1'b1) $display("FAIL reset_rst_out: got %b want 1", mon_if.rst_out); else n_pass++;
            n_checks++;
            if (mon_if.pll_ready !== 1'b0) $display("FAIL reset_pll_ready: got %b want 0", mon_if.pll_ready); else n_pass++;
            n_checks++;
            if (mon_if.freq_count !== '0) $display("FAIL reset_freq_count: got %0d want 0", mon_if.freq_count); else n_pass++;
            n_checks++;
            if (mon_if.fault_flag !== 1'b0) $display("FAIL reset_fault_flag: got %b want 0", mon_if.fault_flag); else n_pass++;
            n_checks++;
            if (mon_if.fault_count !== 8'd0) $display("FAIL reset_fault_count: got %0d want 0", mon_if.fault_count); else n_pass++;
        end
        release_rst();
    endtask

    task automatic test_nominal();
        bit   ok;
        int   cyc;
        exp_t e;
        repeat (5) @(negedge clk);
        for (int w = 0; w < 4; w++) exp_q.push_back('{lo: 385, hi: 386});
        for (int w = 0; w < 4; w++) begin
            wait_cv(ok, cyc);
            n_checks++;
            if (!ok) begin
                $display("FAIL nominal_cv_timeout: window %0d got no count_valid want one", w);
                continue;
            end
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
                $display("FAIL nominal_freq: window %0d got %0d want %0d..%0d", w, mon_if.freq_count, e.lo, e.hi);
            else n_pass++;
            n_checks++;
            if (mon_if.pll_ready !== 1'b0) $display("FAIL nominal_early_ready: window %0d got %b want 0", w, mon_if.pll_ready); else n_pass++;
            if (w > 0) begin
                n_checks++;
                if (cyc != 2700) $display("FAIL nominal_cv_spacing: got %0d want 2700", cyc); else n_pass++;
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (mon_if.pll_ready !== 1'b1) $display("FAIL nominal_ready: got %b want 1", mon_if.pll_ready); else n_pass++;
        n_checks++;
        if (mon_if.rst_out !== 1'b0) $display("FAIL nominal_rst_out: got %b want 0", mon_if.rst_out); else n_pass++;
        n_checks++;
        if (mon_if.count_valid !== 1'b0) $display("FAIL nominal_cv_width: got %b want 0", mon_if.count_valid); else n_pass++;
    endtask

    task automatic test_lock_loss();
        bit   ok;
        int   cyc;
        int   lat;
        exp_t e;
        repeat (100) @(negedge clk);
        mon_if.pll_lock = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (mon_if.rst_out === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat < 2 || lat > 3) $display("FAIL lock_loss_latency: got %0d want 2..3", lat); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (mon_if.fault_flag !== 1'b1) $display("FAIL lock_loss_flag: got %b want 1", mon_if.fault_flag); else n_pass++;
        n_checks++;
        if (mon_if.fault_count !== 8'd1) $display("FAIL lock_loss_count: got %0d want 1", mon_if.fault_count); else n_pass++;
        n_checks++;
        if (mon_if.pll_ready !== 1'b0 || mon_if.rst_out !== 1'b1)
            $display("FAIL lock_loss_outputs: got ready=%b rst_out=%b want ready=0 rst_out=1", mon_if.pll_ready, mon_if.rst_out);
        else n_pass++;
        mon_if.clr_fault = 1'b1;
        @(negedge clk);
        mon_if.clr_fault = 1'b0;
        #1;
        n_checks++;
        if (mon_if.fault_flag !== 1'b0) $display("FAIL clr_fault_flag: got %b want 0", mon_if.fault_flag); else n_pass++;
        n_checks++;
        if (mon_if.fault_count !== 8'd1) $display("FAIL clr_fault_count: got %0d want 1", mon_if.fault_count); else n_pass++;
        mon_if.pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        for (int w = 0; w < 4; w++) exp_q.push_back('{lo: 385, hi: 386});
        for (int w = 0; w < 4; w++) begin
            wait_cv(ok, cyc);
            n_checks++;
            if (!ok) begin
                $display("FAIL relock_cv_timeout: window %0d got no count_valid want one", w);
                continue;
            end
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
                $display("FAIL relock_freq: window %0d got %0d want %0d..%0d", w, mon_if.freq_count, e.lo, e.hi);
            else n_pass++;
            n_checks++;
            if (mon_if.pll_ready !== 1'b0) $display("FAIL relock_early_ready: window %0d got %b want 0", w, mon_if.pll_ready); else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (mon_if.pll_ready !== 1'b1 || mon_if.rst_out !== 1'b0)
            $display("FAIL relock_ready: got ready=%b rst_out=%b want ready=1 rst_out=0", mon_if.pll_ready, mon_if.rst_out);
        else n_pass++;
    endtask

    task automatic test_bad_window();
        bit   ok;
        int   cyc;
        exp_t e;
        // One more in-range window while READY, used to find the window phase.
        exp_q.push_back('{lo: 380, hi: 392});
        wait_cv(ok, cyc);
        n_checks++;
        if (!ok) $display("FAIL bad_window_sync_timeout: got no count_valid want one"); else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
            $display("FAIL bad_window_sync_freq: got %0d want %0d..%0d", mon_if.freq_count, e.lo, e.hi);
        else n_pass++;
        // Stop pll_clk about 20 cycles before the next close: that window is
        // still in range, the one after it counts nothing.
        exp_q.push_back('{lo: 380, hi: 386});
        exp_q.push_back('{lo: 0, hi: 0});
        repeat (2679) @(negedge clk);
        gen_en = 1'b0;
        wait_cv(ok, cyc);
        n_checks++;
        if (!ok) $display("FAIL bad_window_a_timeout: got no count_valid want one"); else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
            $display("FAIL bad_window_a_freq: got %0d want %0d..%0d", mon_if.freq_count, e.lo, e.hi);
        else n_pass++;
        // Hold clr_fault across the fault so the set/clear priority is exercised.
        mon_if.clr_fault = 1'b1;
        wait_cv(ok, cyc);
        n_checks++;
        if (!ok) $display("FAIL bad_window_b_timeout: got no count_valid want one"); else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
            $display("FAIL bad_window_b_freq: got %0d want %0d..%0d", mon_if.freq_count, e.lo, e.hi);
        else n_pass++;
        n_checks++;
        if (mon_if.pll_ready !== 1'b1) $display("FAIL bad_window_ready_before: got %b want 1", mon_if.pll_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (mon_if.rst_out !== 1'b1 || mon_if.pll_ready !== 1'b0)
            $display("FAIL bad_window_fault_entry: got rst_out=%b ready=%b want rst_out=1 ready=0", mon_if.rst_out, mon_if.pll_ready);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (mon_if.fault_flag !== 1'b1) $display("FAIL bad_window_set_wins: got %b want 1", mon_if.fault_flag); else n_pass++;
        n_checks++;
        if (mon_if.fault_count !== 8'd2) $display("FAIL bad_window_count: got %0d want 2", mon_if.fault_count); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (mon_if.fault_flag !== 1'b0) $display("FAIL bad_window_clr_after: got %b want 0", mon_if.fault_flag); else n_pass++;
        mon_if.clr_fault = 1'b0;
        gen_en = 1'b1;
    endtask

    task automatic test_rst_mid_measure();
        bit   ok;
        int   cyc;
        exp_t e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        release_rst();
        repeat (5) @(negedge clk);
        for (int w = 0; w < 2; w++) exp_q.push_back('{lo: 385, hi: 386});
        for (int w = 0; w < 2; w++) begin
            wait_cv(ok, cyc);
            n_checks++;
            if (!ok) begin
                $display("FAIL pre_rst_cv_timeout: window %0d got no count_valid want one", w);
                continue;
            end
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
                $display("FAIL pre_rst_freq: window %0d got %0d want %0d..%0d", w, mon_if.freq_count, e.lo, e.hi);
            else n_pass++;
        end
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (mon_if.freq_count !== '0) $display("FAIL mid_rst_freq: got %0d want 0", mon_if.freq_count); else n_pass++;
        n_checks++;
        if (mon_if.rst_out !== 1'b1 || mon_if.pll_ready !== 1'b0)
            $display("FAIL mid_rst_outputs: got rst_out=%b ready=%b want rst_out=1 ready=0", mon_if.rst_out, mon_if.pll_ready);
        else n_pass++;
        repeat (3) @(negedge clk);
        release_rst();
        repeat (5) @(negedge clk);
        for (int w = 0; w < 4; w++) exp_q.push_back('{lo: 385, hi: 386});
        for (int w = 0; w < 4; w++) begin
            wait_cv(ok, cyc);
            n_checks++;
            if (!ok) begin
                $display("FAIL post_rst_cv_timeout: window %0d got no count_valid want one", w);
                continue;
            end
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
                $display("FAIL post_rst_freq: window %0d got %0d want %0d..%0d", w, mon_if.freq_count, e.lo, e.hi);
            else n_pass++;
            @(negedge clk);
            #1;
            n_checks++;
            if (mon_if.pll_ready !== (w == 3))
                $display("FAIL post_rst_ready: after window %0d got %b want %b", w, mon_if.pll_ready, (w == 3));
            else n_pass++;
        end
    endtask

    task automatic test_fast_clock();
        bit   ok;
        int   cyc;
        exp_t e;
        rst     = 1'b1;
        gen_per = 6;
        gen_hi  = 3;
        repeat (3) @(negedge clk);
        release_rst();
        repeat (5) @(negedge clk);
        for (int w = 0; w < 2; w++) exp_q.push_back('{lo: 450, hi: 450});
        for (int w = 0; w < 2; w++) begin
            wait_cv(ok, cyc);
            n_checks++;
            if (!ok) begin
                $display("FAIL fast_cv_timeout: window %0d got no count_valid want one", w);
                continue;
            end
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(mon_if.freq_count) < e.lo || int'(mon_if.freq_count) > e.hi)
                $display("FAIL fast_freq: window %0d got %0d want %0d", w, mon_if.freq_count, e.lo);
            else n_pass++;
            @(negedge clk);
            #1;
            n_checks++;
            if (mon_if.rst_out !== 1'b1 || mon_if.pll_ready !== 1'b0 || mon_if.fault_flag !== 1'b0)
                $display("FAIL fast_held: got rst_out=%b ready=%b fault=%b want 1 0 0", mon_if.rst_out, mon_if.pll_ready, mon_if.fault_flag);
            else n_pass++;
        end
    endtask

    initial begin
        mon_if.pll_clk   = 1'b0;
        mon_if.pll_lock  = 1'b0;
        mon_if.clr_fault = 1'b0;
        test_reset();
        test_nominal();
        test_lock_loss();
        test_bad_window();
        test_rst_mid_measure();
        test_fast_clock();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
